// File: rtl/uart_rx_deserializer.sv
// UART receiver: detects a start bit, samples each bit as a 2-of-3 majority
// around mid-bit, and checks optional parity and the stop bit.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [5:0]            presc_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [5:0]            edge_q;
    logic [5:0]            edge_d;
    logic [BW-1:0]         bit_q;
    logic [2:0]            smp_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q;
    logic                  stp_bad_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic [5:0] half;
    logic       at_dec;
    logic       at_end;
    logic       maj;

    assign half   = {1'b0, presc_q[5:1]};
    assign at_dec = (edge_q == half + 6'd2);
    assign at_end = (edge_q == presc_q - 6'd1);
    assign edge_d = at_end ? 6'd0 : edge_q + 6'd1;
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    // Bit decisions are taken at half+2, always before the bit's last edge,
    // so the stop/parity verdicts are settled when the frame end is reached.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            presc_q   <= 6'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            edge_q    <= 6'd0;
            bit_q     <= '0;
            smp_q     <= 3'b000;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            stp_bad_q <= 1'b0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            if (state_q == IDLE) begin
                if (!RX_IN) begin
                    state_q   <= START;
                    presc_q   <= PRESCALE;
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                    edge_q    <= 6'd1;
                    bit_q     <= '0;
                    par_bad_q <= 1'b0;
                    stp_bad_q <= 1'b0;
                end
            end else begin
                edge_q <= edge_d;
                for (int i = 0; i < 3; i++) begin
                    if (edge_q == half - 6'd1 + 6'(i)) begin
                        smp_q[i] <= RX_IN;
                    end
                end
                case (state_q)
                    START: begin
                        if (at_dec && maj) begin
                            state_q <= IDLE;
                            edge_q  <= 6'd0;
                        end else if (at_end) begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (at_dec) begin
                            shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                        end
                        if (at_end) begin
                            if (bit_q == LAST_BIT) begin
                                bit_q   <= '0;
                                state_q <= par_en_q ? PARITY : STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (at_dec) begin
                            par_bad_q <= maj ^ (^shift_q) ^ par_typ_q;
                        end
                        if (at_end) begin
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (at_dec) begin
                            stp_bad_q <= ~maj;
                        end
                        if (at_end) begin
                            state_q   <= IDLE;
                            edge_q    <= 6'd0;
                            par_err_q <= par_bad_q;
                            stp_err_q <= stp_bad_q;
                            if (!par_bad_q && !stp_bad_q) begin
                                valid_q  <= 1'b1;
                                p_data_q <= shift_q;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        edge_q  <= 6'd0;
                    end
                endcase
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frame table, glitch and reset
// sequences, and random frame streams checked cycle by cycle against a line-level model.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;
    localparam int DW     = 8;
    localparam int MAXLEN = 8192;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic          RX_IN    = 1'b1;
    logic [5:0]    PRESCALE = 6'd8;
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;

    uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Stream buffers: per-cycle line level and config inputs, observed and expected outputs.
    logic          line_a [MAXLEN];
    logic [5:0]    cp     [MAXLEN];
    logic          cpe    [MAXLEN];
    logic          cpt    [MAXLEN];
    logic [DW+2:0] obs    [MAXLEN];
    logic [DW+2:0] expv   [MAXLEN];
    logic          mv     [MAXLEN];
    logic          mp     [MAXLEN];
    logic          ms     [MAXLEN];
    logic [DW-1:0] md     [MAXLEN];
    int            wr;
    logic [DW-1:0] model_pdata;

    typedef struct {
        logic [5:0]    p;
        logic          pe;
        logic          pt;
        logic [DW-1:0] d;
        logic          pb;
        logic          sb;
        int            gap;
        int            lat;
        logic          ev;
        logic          ep;
        logic          es;
        logic [DW-1:0] edata;
    } vec_t;

    function automatic logic [5:0] rand_p();
        case ($urandom_range(0, 2))
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    task automatic push(input logic v);
        line_a[wr] = v;
        cp[wr]     = rand_p();
        cpe[wr]    = 1'($urandom);
        cpt[wr]    = 1'($urandom);
        wr++;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b1);
    endtask

    task automatic add_frame(input logic [5:0] p, input logic pe, input logic pt,
                             input logic [DW-1:0] d, input logic pb, input logic sb,
                             output int det);
        logic bits [DW+3];
        int   nb;
        det     = wr;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = d[i];
        nb = DW + 1;
        if (pe) begin
            bits[nb] = pb;
            nb++;
        end
        bits[nb] = sb;
        nb++;
        for (int b = 0; b < nb; b++)
            for (int c = 0; c < int'(p); c++) push(bits[b]);
        cp[det]  = p;
        cpe[det] = pe;
        cpt[det] = pt;
    endtask

    function automatic logic line_at(input int i);
        return (i < wr) ? line_a[i] : 1'b1;
    endfunction

    // Value of bit b of a frame detected at t: majority of the three mid-bit line samples.
    function automatic logic maj3(input int t, input int p, input int b);
        int base;
        int ones;
        base = t + b * p + p / 2 - 1;
        ones = int'(line_at(base)) + int'(line_at(base + 1)) + int'(line_at(base + 2));
        return ones >= 2;
    endfunction

    task automatic build_model();
        int            t;
        int            p;
        int            n;
        logic          pe;
        logic          pt;
        logic          perr;
        logic          serr;
        logic [DW-1:0] d;
        logic [DW-1:0] pd;
        for (int k = 0; k < wr; k++) begin
            mv[k] = 1'b0; mp[k] = 1'b0; ms[k] = 1'b0; md[k] = '0;
        end
        t = 0;
        while (t < wr) begin
            if (line_a[t] == 1'b0) begin
                p  = int'(cp[t]);
                pe = cpe[t];
                pt = cpt[t];
                n  = DW + 2 + (pe ? 1 : 0);
                if (maj3(t, p, 0)) begin
                    t = t + p / 2 + 3;
                end else begin
                    for (int b = 0; b < DW; b++) d[b] = maj3(t, p, b + 1);
                    perr = pe && (maj3(t, p, DW + 1) != ((^d) ^ pt));
                    serr = !maj3(t, p, n - 1);
                    if (t + n * p < wr) begin
                        mv[t+n*p] = !perr && !serr;
                        mp[t+n*p] = perr;
                        ms[t+n*p] = serr;
                        md[t+n*p] = d;
                    end
                    t = t + n * p;
                end
            end else begin
                t++;
            end
        end
        pd = model_pdata;
        for (int k = 0; k < wr; k++) begin
            if (mv[k]) pd = md[k];
            expv[k] = {mv[k], mp[k], ms[k], pd};
        end
        model_pdata = pd;
    endtask

    // Entry point must be just after a rising edge; obs[k] is what edge k sees.
    task automatic run_stream(input int n);
        for (int k = 0; k < n; k++) begin
            RX_IN    = line_a[k];
            PRESCALE = cp[k];
            PAR_EN   = cpe[k];
            PAR_TYP  = cpt[k];
            @(negedge CLK);
            obs[k] = {DATA_VALID, PAR_ERR, STP_ERR, P_DATA};
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_stream(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                failures++;
                $display("FAIL %s cycle %0d: got v/pe/se=%b data=%h, expected v/pe/se=%b data=%h",
                         name, k, obs[k][DW+2:DW], obs[k][DW-1:0],
                         expv[k][DW+2:DW], expv[k][DW-1:0]);
            end
        end
    endtask

    initial begin
        vec_t          vecs [8];
        int            dets [8];
        int            det_a;
        int            det_b;
        int            d;
        int            n;
        int            pos;
        logic [5:0]    rp;
        logic          rpe;
        logic          rpt;
        logic [DW-1:0] rdat;
        logic          rpb;
        logic          rsb;

        vecs[0] = '{6'd8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 3, 88,  1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{6'd16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2, 160, 1'b1, 1'b0, 1'b0, 8'h3C};
        vecs[2] = '{6'd16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 160, 1'b1, 1'b0, 1'b0, 8'hFF};
        vecs[3] = '{6'd8,  1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 2, 88,  1'b0, 1'b1, 1'b0, 8'hFF};
        vecs[4] = '{6'd32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1, 320, 1'b0, 1'b0, 1'b1, 8'hFF};
        vecs[5] = '{6'd8,  1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 2, 88,  1'b0, 1'b1, 1'b1, 8'hFF};
        vecs[6] = '{6'd16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 0, 176, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{6'd32, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 3, 352, 1'b1, 1'b0, 1'b0, 8'h80};

        // Asynchronous reset before any clock edge.
        #2 RST = 1'b0;
        #1;
        check_val("reset_p_data", 32'(P_DATA), 32'h0);
        check_val("reset_data_valid", 32'(DATA_VALID), 32'h0);
        check_val("reset_par_err", 32'(PAR_ERR), 32'h0);
        check_val("reset_stp_err", 32'(STP_ERR), 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        model_pdata = '0;

        // Directed frame table.
        wr = 0;
        add_idle(3);
        for (int i = 0; i < 8; i++) begin
            add_idle(vecs[i].gap);
            add_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d, vecs[i].pb, vecs[i].sb, dets[i]);
        end
        add_idle(4);
        run_stream(wr);
        build_model();
        check_stream("table_stream", wr);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("vec%0d_result", i), 32'(obs[dets[i] + vecs[i].lat]),
                      32'({vecs[i].ev, vecs[i].ep, vecs[i].es, vecs[i].edata}));
            check_val($sformatf("vec%0d_no_early_flag", i),
                      32'(obs[dets[i] + vecs[i].lat - 1][DW+2:DW]), 32'h0);
            $display("vector %0d: presc=%0d par_en=%0d data=%h -> valid=%b par_err=%b stp_err=%b p_data=%h",
                     i, vecs[i].p, vecs[i].pe, vecs[i].d, obs[dets[i] + vecs[i].lat][DW+2],
                     obs[dets[i] + vecs[i].lat][DW+1], obs[dets[i] + vecs[i].lat][DW],
                     obs[dets[i] + vecs[i].lat][DW-1:0]);
        end

        // False start (2 low cycles) then a real frame exactly when IDLE resumes,
        // followed by a frame with single-cycle glitches on sample points.
        wr = 0;
        add_idle(3);
        d = wr;
        push(1'b0);
        push(1'b0);
        cp[d] = 6'd8;
        add_idle(5);
        add_frame(6'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, det_a);
        add_idle(3);
        add_frame(6'd16, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, det_b);
        line_a[det_b + 3 * 16 + 8] = 1'b1;
        line_a[det_b + 7 * 16 + 7] = 1'b0;
        add_idle(4);
        run_stream(wr);
        build_model();
        check_stream("glitch_stream", wr);
        check_val("glitch_then_frame", 32'(obs[d + 7 + 80]), 32'({3'b100, 8'h5A}));
        check_val("data_bit_glitch", 32'(obs[det_b + 176]), 32'({3'b100, 8'hC3}));
        $display("glitch: frame after false start p_data=%h, glitched frame p_data=%h",
                 obs[d + 87][DW-1:0], obs[det_b + 176][DW-1:0]);

        // Random frame streams with random config, gaps, errors and glitches.
        for (int s = 0; s < 3; s++) begin
            wr = 0;
            add_idle(2);
            for (int f = 0; f < 10; f++) begin
                add_idle(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)));
                rp   = rand_p();
                rpe  = 1'($urandom);
                rpt  = 1'($urandom);
                rdat = 8'($urandom);
                rpb  = (^rdat) ^ rpt;
                if ($urandom_range(0, 3) == 0) rpb = ~rpb;
                rsb  = ($urandom_range(0, 5) != 0);
                add_frame(rp, rpe, rpt, rdat, rpb, rsb, det_a);
                n = DW + 2 + (rpe ? 1 : 0);
                if ($urandom_range(0, 1) == 1) begin
                    pos = int'($urandom_range(1, n * int'(rp) - 1));
                    line_a[det_a + pos] = ~line_a[det_a + pos];
                end
            end
            add_idle(4);
            run_stream(wr);
            build_model();
            check_stream($sformatf("random_stream%0d", s), wr);
            $display("random stream %0d: %0d cycles compared, last p_data=%h", s, wr, obs[wr-1][DW-1:0]);
        end

        // Reset asserted during data bit 4 of a frame.
        wr = 0;
        add_idle(3);
        add_frame(6'd8, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, det_a);
        add_idle(2);
        add_frame(6'd8, 1'b0, 1'b0, 8'hE7, 1'b0, 1'b1, det_b);
        add_idle(4);
        build_model();
        n = det_b + 5 * 8 + 2;
        run_stream(n);
        check_stream("pre_reset_stream", n);
        RX_IN = 1'b1;
        #2 RST = 1'b0;
        #1;
        check_val("midframe_reset_p_data", 32'(P_DATA), 32'h0);
        check_val("midframe_reset_data_valid", 32'(DATA_VALID), 32'h0);
        check_val("midframe_reset_par_err", 32'(PAR_ERR), 32'h0);
        check_val("midframe_reset_stp_err", 32'(STP_ERR), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        model_pdata = '0;
        wr = 0;
        add_idle(3);
        add_frame(6'd16, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, det_a);
        add_idle(4);
        run_stream(wr);
        build_model();
        check_stream("post_reset_stream", wr);
        check_val("post_reset_frame", 32'(obs[det_a + 176]), 32'({3'b100, 8'h81}));
        $display("reset: mid-frame abort, next frame p_data=%h", obs[det_a + 176][DW-1:0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
